// File: rtl/eedc_decoder_if.sv
// Stream bundle between the EEDC link and the decoder: codeword in, corrected word and flags out.
// The decoder attaches through the slave modport; the upstream/downstream side uses master.
interface eedc_decoder_if;
  logic [10:0] encoded_input;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  data_output;
  logic [3:0]  syndrome;
  logic        err_corrected;
  logic        err_uncorrectable;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output encoded_input, in_valid, out_ready,
    input  in_ready, data_output, syndrome, err_corrected, err_uncorrectable, out_valid
  );

  modport slave (
    input  encoded_input, in_valid, out_ready,
    output in_ready, data_output, syndrome, err_corrected, err_uncorrectable, out_valid
  );
endinterface

// File: rtl/eedc_decoder.sv
// EEDC single-error-correcting decoder: syndrome stage, correction stage, valid/ready
// backpressure and saturating counters of corrected and uncorrectable words.
module eedc_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  eedc_decoder_if.slave    bus,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] corrected_count,
  output logic [CNT_W-1:0] uncorrectable_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  function automatic logic [3:0] calc_syndrome(input logic [10:0] e);
    logic [3:0] s;
    s[3] = e[3] ^ e[10] ^ e[8] ^ e[6] ^ e[4];
    s[2] = e[2] ^ e[9]  ^ e[8] ^ e[5] ^ e[4];
    s[1] = e[1] ^ e[7]  ^ e[6] ^ e[5] ^ e[4];
    s[0] = e[0] ^ e[3]  ^ e[2] ^ e[1];
    return s;
  endfunction

  // Maps {s3,s2,s1} of a data error onto the data bit to flip (d6..d0).
  function automatic logic [6:0] data_flip_mask(input logic [2:0] pos);
    logic [6:0] m;
    case (pos)
      3'b100:  m = 7'b1000000;
      3'b010:  m = 7'b0100000;
      3'b110:  m = 7'b0010000;
      3'b001:  m = 7'b0001000;
      3'b101:  m = 7'b0000100;
      3'b011:  m = 7'b0000010;
      3'b111:  m = 7'b0000001;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

  logic             s1_valid_r;
  logic [6:0]       s1_data_r;
  logic [3:0]       s1_syn_r;
  logic             out_valid_r;
  logic [6:0]       data_r;
  logic [3:0]       syn_r;
  logic             corr_r;
  logic             unc_r;
  logic [CNT_W-1:0] corr_cnt_r;
  logic [CNT_W-1:0] unc_cnt_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             s2_load_s;
  logic [6:0]       fix_data_s;
  logic             fix_corr_s;
  logic             fix_unc_s;

  assign s2_adv_s  = !out_valid_r || bus.out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign s2_load_s = s2_adv_s && s1_valid_r;

  assign bus.in_ready          = s1_adv_s;
  assign bus.out_valid         = out_valid_r;
  assign bus.data_output       = data_r;
  assign bus.syndrome          = syn_r;
  assign bus.err_corrected     = corr_r;
  assign bus.err_uncorrectable = unc_r;
  assign corrected_count       = corr_cnt_r;
  assign uncorrectable_count   = unc_cnt_r;

  // Classify the stage-1 syndrome and build the corrected data word.
  always_comb begin
    fix_data_s = s1_data_r;
    fix_corr_s = 1'b0;
    fix_unc_s  = 1'b0;
    if (s1_syn_r == 4'b0000) begin
      fix_data_s = s1_data_r;
    end else if (!s1_syn_r[0]) begin
      fix_data_s = s1_data_r ^ data_flip_mask(s1_syn_r[3:1]);
      fix_corr_s = 1'b1;
    end else begin
      // Odd overall check parity: a lone check-bit error only if at most one high syndrome bit.
      case (s1_syn_r[3:1])
        3'b100, 3'b010, 3'b001, 3'b000: fix_corr_s = 1'b1;
        default:                        fix_unc_s  = 1'b1;
      endcase
    end
  end

  // Stage 1: capture the data bits and syndrome of an accepted codeword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 7'd0;
      s1_syn_r   <= 4'd0;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_r <= bus.encoded_input[10:4];
        s1_syn_r  <= calc_syndrome(bus.encoded_input);
      end
    end
  end

  // Stage 2: output registers; they only change when downstream can take a new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      data_r      <= 7'd0;
      syn_r       <= 4'd0;
      corr_r      <= 1'b0;
      unc_r       <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        data_r <= fix_data_s;
        syn_r  <= s1_syn_r;
        corr_r <= fix_corr_s;
        unc_r  <= fix_unc_s;
      end
    end
  end

  // Saturating statistics; a clear wins over an increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_r <= '0;
      unc_cnt_r  <= '0;
    end else if (clear_counts) begin
      corr_cnt_r <= '0;
      unc_cnt_r  <= '0;
    end else if (s2_load_s) begin
      if (fix_corr_s && (corr_cnt_r != CNT_MAX)) begin
        corr_cnt_r <= corr_cnt_r + CNT_ONE;
      end
      if (fix_unc_s && (unc_cnt_r != CNT_MAX)) begin
        unc_cnt_r <= unc_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_eedc_decoder.sv
// Self-checking bench for eedc_decoder: directed code words, randomized backpressure stream
// against a brute-force single-flip decoding model, counter saturation/clear and mid-stream reset.
module tb_eedc_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear1 = 1'b0;
  logic        clear2 = 1'b0;
  logic [15:0] cc1, uc1;
  logic [1:0]  cc2, uc2;
  int          checks = 0;
  int          errors = 0;

  eedc_decoder_if bus1();
  eedc_decoder_if bus2();

  eedc_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus1.slave), .clear_counts(clear1),
    .corrected_count(cc1), .uncorrectable_count(uc1)
  );

  eedc_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2.slave), .clear_counts(clear2),
    .corrected_count(cc2), .uncorrectable_count(uc2)
  );

  always #5 clk = ~clk;

  // Syndrome column ({s3,s2,s1}) covered by data bit d(6-i).
  function automatic logic [2:0] col_of(input int i);
    case (i)
      0: return 3'd4;
      1: return 3'd2;
      2: return 3'd6;
      3: return 3'd1;
      4: return 3'd5;
      5: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [3:0] ref_syndrome(input logic [10:0] e);
    logic [2:0] top;
    top = e[3:1];
    for (int i = 0; i < 7; i++) if (e[10-i]) top ^= col_of(i);
    return {top, ^e[3:0]};
  endfunction

  function automatic logic [10:0] encode(input logic [6:0] d);
    logic [2:0] top;
    top = 3'd0;
    for (int i = 0; i < 7; i++) if (d[6-i]) top ^= col_of(i);
    return {d, top, ^top};
  endfunction

  // Correctable means some single flip yields a clean syndrome.
  function automatic void ref_decode(input logic [10:0] e, output logic [6:0] d,
                                     output logic [3:0] s, output logic c, output logic u);
    logic [10:0] f;
    s = ref_syndrome(e);
    d = e[10:4];
    c = 1'b0;
    u = (s != 4'd0);
    for (int b = 0; b < 11; b++) begin
      f = e ^ (11'd1 << b);
      if (s != 4'd0 && ref_syndrome(f) == 4'd0) begin
        d = f[10:4];
        c = 1'b1;
        u = 1'b0;
      end
    end
  endfunction

  function automatic logic [10:0] rand_word(input int nflip);
    logic [10:0] e;
    e = encode(7'($urandom));
    for (int k = 0; k < nflip; k++) e[$urandom_range(0, 10)] ^= 1'b1;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.encoded_input = 11'd0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.encoded_input = 11'd0;
    clear1 = 1'b0; clear2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_single(input logic [10:0] w, output logic mid_valid);
    @(negedge clk);
    bus1.encoded_input = w; bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    mid_valid = bus1.out_valid;
    @(negedge clk);
  endtask

  task automatic drain1();
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.encoded_input = 11'd0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.encoded_input = 11'd0;
    @(negedge clk);
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_handshake in_ready=%b out_valid=%b exp 1/0", bus1.in_ready, bus1.out_valid); end
    checks++;
    if (bus1.data_output !== 7'd0 || bus1.syndrome !== 4'd0 || bus1.err_corrected !== 1'b0 || bus1.err_uncorrectable !== 1'b0)
      begin errors++; $display("FAIL reset_outputs data=%h syn=%b c=%b u=%b exp all 0", bus1.data_output, bus1.syndrome, bus1.err_corrected, bus1.err_uncorrectable); end
    checks++;
    if (cc1 !== 16'd0 || uc1 !== 16'd0)
      begin errors++; $display("FAIL reset_counts cc=%0d uc=%0d exp 0/0", cc1, uc1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [10:0] w [5];
    logic [6:0]  ed [5];
    logic [3:0]  es [5];
    logic        ec [5];
    logic        eu [5];
    logic [15:0] ecc [5];
    logic [15:0] euc [5];
    logic        mid;
    w[0] = 11'h550; ed[0] = 7'h55; es[0] = 4'b0000; ec[0] = 1'b0; eu[0] = 1'b0; ecc[0] = 16'd0; euc[0] = 16'd0;
    w[1] = 11'h450; ed[1] = 7'h55; es[1] = 4'b1100; ec[1] = 1'b1; eu[1] = 1'b0; ecc[1] = 16'd1; euc[1] = 16'd0;
    w[2] = 11'h551; ed[2] = 7'h55; es[2] = 4'b0001; ec[2] = 1'b1; eu[2] = 1'b0; ecc[2] = 16'd2; euc[2] = 16'd0;
    w[3] = 11'h558; ed[3] = 7'h55; es[3] = 4'b1001; ec[3] = 1'b1; eu[3] = 1'b0; ecc[3] = 16'd3; euc[3] = 16'd0;
    w[4] = 11'h154; ed[4] = 7'h15; es[4] = 4'b1101; ec[4] = 1'b0; eu[4] = 1'b1; ecc[4] = 16'd3; euc[4] = 16'd1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_single(w[i], mid);
      checks++;
      if (mid !== 1'b0 || bus1.out_valid !== 1'b1)
        begin errors++; $display("FAIL latency w=%h mid=%b final=%b exp 0/1", w[i], mid, bus1.out_valid); end
      checks++;
      if (bus1.data_output !== ed[i] || bus1.syndrome !== es[i] || bus1.err_corrected !== ec[i] || bus1.err_uncorrectable !== eu[i])
        begin errors++; $display("FAIL directed w=%h got d=%h s=%b c=%b u=%b exp d=%h s=%b c=%b u=%b", w[i],
          bus1.data_output, bus1.syndrome, bus1.err_corrected, bus1.err_uncorrectable, ed[i], es[i], ec[i], eu[i]); end
      checks++;
      if (cc1 !== ecc[i] || uc1 !== euc[i])
        begin errors++; $display("FAIL directed_counts w=%h cc=%0d uc=%0d exp %0d/%0d", w[i], cc1, uc1, ecc[i], euc[i]); end
      drain1();
    end
  endtask

  task automatic test_backpressure_stream();
    localparam int N = 200;
    logic [10:0] q [$];
    logic [10:0] word, exp_w;
    logic        have, prev_stall, ec, eu;
    logic [6:0]  ed, prev_d;
    logic [3:0]  es, prev_s;
    logic [15:0] mc, mu;
    int          sent, cycles;
    have = 1'b0; prev_stall = 1'b0; word = 11'd0; sent = 0; cycles = 0;
    mc = 16'd0; mu = 16'd0; prev_d = 7'd0; prev_s = 4'd0;
    do_reset();
    while ((sent < N || q.size() != 0) && cycles < 5000) begin
      cycles++;
      @(negedge clk);
      bus1.out_ready = 1'($urandom_range(0, 1));
      if (!have && sent < N && $urandom_range(0, 3) != 0) begin
        word = rand_word($urandom_range(0, 2));
        have = 1'b1;
      end
      bus1.in_valid = have;
      bus1.encoded_input = word;
      #1;
      checks++;
      if (bus1.in_ready !== ((q.size() < 2) || bus1.out_ready))
        begin errors++; $display("FAIL in_ready occ=%0d out_ready=%b got=%b", q.size(), bus1.out_ready, bus1.in_ready); end
      if (prev_stall) begin
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.data_output !== prev_d || bus1.syndrome !== prev_s)
          begin errors++; $display("FAIL stall_hold v=%b d=%h s=%b exp 1 d=%h s=%b", bus1.out_valid, bus1.data_output, bus1.syndrome, prev_d, prev_s); end
      end
      if (bus1.out_valid && bus1.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL spurious_output d=%h with no word outstanding", bus1.data_output);
        end else begin
          exp_w = q.pop_front();
          ref_decode(exp_w, ed, es, ec, eu);
          if (ec && mc != 16'hFFFF) mc++;
          if (eu && mu != 16'hFFFF) mu++;
          if (bus1.data_output !== ed || bus1.syndrome !== es || bus1.err_corrected !== ec ||
              bus1.err_uncorrectable !== eu || cc1 !== mc || uc1 !== mu)
            begin errors++; $display("FAIL stream w=%h got d=%h s=%b c=%b u=%b cc=%0d uc=%0d exp d=%h s=%b c=%b u=%b cc=%0d uc=%0d",
              exp_w, bus1.data_output, bus1.syndrome, bus1.err_corrected, bus1.err_uncorrectable, cc1, uc1, ed, es, ec, eu, mc, mu); end
        end
      end
      prev_stall = bus1.out_valid && !bus1.out_ready;
      prev_d = bus1.data_output;
      prev_s = bus1.syndrome;
      if (have && bus1.in_ready) begin
        q.push_back(word);
        sent++;
        have = 1'b0;
      end
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    checks++;
    if (sent != N || q.size() != 0)
      begin errors++; $display("FAIL stream_timeout sent=%0d pending=%0d exp %0d/0", sent, q.size(), N); end
  endtask

  task automatic test_saturation_and_clear();
    logic [10:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      w = encode(7'($urandom));
      w[$urandom_range(4, 10)] ^= 1'b1;
      bus2.in_valid = 1'b1; bus2.encoded_input = w;
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cc2 !== 2'd3 || uc2 !== 2'd0)
      begin errors++; $display("FAIL saturate cc=%0d uc=%0d exp 3/0", cc2, uc2); end
    @(negedge clk);
    w = encode(7'h2A) ^ 11'h020;
    bus2.in_valid = 1'b1; bus2.encoded_input = w;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    clear2 = 1'b1;
    @(negedge clk);
    clear2 = 1'b0;
    checks++;
    if (cc2 !== 2'd0 || bus2.out_valid !== 1'b1 || bus2.err_corrected !== 1'b1 || bus2.data_output !== 7'h2A)
      begin errors++; $display("FAIL clear_vs_inc cc=%0d v=%b c=%b d=%h exp 0/1/1/2a", cc2, bus2.out_valid, bus2.err_corrected, bus2.data_output); end
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.encoded_input = encode(7'h11) ^ 11'h001;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cc2 !== 2'd1)
      begin errors++; $display("FAIL count_after_clear cc=%0d exp 1", cc2); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    @(negedge clk);
    bus1.out_ready = 1'b0; bus1.in_valid = 1'b1; bus1.encoded_input = encode(7'h33) ^ 11'h100;
    @(negedge clk);
    bus1.encoded_input = encode(7'h44) ^ 11'h040;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    checks++;
    if (cc1 !== 16'd1 || bus1.out_valid !== 1'b1 || bus1.in_ready !== 1'b0)
      begin errors++; $display("FAIL prereset_fill cc=%0d v=%b rdy=%b exp 1/1/0", cc1, bus1.out_valid, bus1.in_ready); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus1.out_valid !== 1'b0 || cc1 !== 16'd0 || uc1 !== 16'd0 || bus1.in_ready !== 1'b1)
      begin errors++; $display("FAIL midreset v=%b cc=%0d uc=%0d rdy=%b exp 0/0/0/1", bus1.out_valid, cc1, uc1, bus1.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.encoded_input = encode(7'h5A); bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    checks++;
    if (bus1.out_valid !== 1'b0)
      begin errors++; $display("FAIL stale_word v=%b d=%h exp 0", bus1.out_valid, bus1.data_output); end
    @(negedge clk);
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.data_output !== 7'h5A || bus1.err_corrected !== 1'b0)
      begin errors++; $display("FAIL first_after_reset v=%b d=%h c=%b exp 1/5a/0", bus1.out_valid, bus1.data_output, bus1.err_corrected); end
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure_stream();
    test_saturation_and_clear();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
